// File: rtl/regfile_mp_sb_pkg.sv
// Shared constants and helpers for the multi-port register file with a write-pending scoreboard.
package regfile_mp_sb_pkg;

  localparam int unsigned REG_ADDR_W = 4;
  localparam logic [REG_ADDR_W-1:0] PC_IDX = 4'd15;
  localparam int unsigned NUM_WR = 2;
  localparam int unsigned CNT_W = 5;

  // Value loaded into register idx on reset.
  function automatic int unsigned rst_val(input int unsigned idx);
    return idx;
  endfunction

endpackage

// File: rtl/regfile_mp_sb_if.sv
// ID/WB-side bus of the register file: read ports, write ports, issue and flush.
interface regfile_mp_sb_if
  import regfile_mp_sb_pkg::*;
#(
  parameter int unsigned DATA_LEN = 32,
  parameter int unsigned NUM_RD   = 3
);

  logic [NUM_RD*REG_ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_LEN-1:0]   rd_data;
  logic [NUM_RD-1:0]            rd_hazard;
  logic [NUM_WR-1:0]            wr_en;
  logic [NUM_WR*REG_ADDR_W-1:0] wr_addr;
  logic [NUM_WR*DATA_LEN-1:0]   wr_data;
  logic                         iss_en;
  logic [REG_ADDR_W-1:0]        iss_dest;
  logic                         flush;
  logic [CNT_W-1:0]             pending_cnt;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_dest, flush,
    input  rd_data, rd_hazard, pending_cnt
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_dest, flush,
    output rd_data, rd_hazard, pending_cnt
  );

endinterface

// File: rtl/regfile_mp_sb_scoreboard.sv
// Per-register write-pending bits and a running count of them.
module regfile_mp_sb_scoreboard
  import regfile_mp_sb_pkg::*;
#(
  parameter int unsigned NUM_REGS = 15
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush_i,
  input  logic                         set_en_i,
  input  logic [REG_ADDR_W-1:0]        set_idx_i,
  input  logic [NUM_WR-1:0]            clr_en_i,
  input  logic [NUM_WR*REG_ADDR_W-1:0] clr_idx_i,
  output logic [NUM_REGS-1:0]          pending_o,
  output logic [CNT_W-1:0]             pending_cnt_o
);

  logic [NUM_REGS-1:0] pend_q, pend_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    n_rise, n_fall;

  // Set is applied after clears so a new producer keeps ownership.
  always_comb begin
    pend_d = pend_q;
    n_rise = '0;
    n_fall = '0;
    if (flush_i) begin
      pend_d = '0;
    end else begin
      for (int unsigned p = 0; p < NUM_WR; p++) begin
        if (clr_en_i[p]) pend_d[clr_idx_i[p*REG_ADDR_W +: REG_ADDR_W]] = 1'b0;
      end
      if (set_en_i) pend_d[set_idx_i] = 1'b1;
    end
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      n_rise = n_rise + CNT_W'(pend_d[i] & ~pend_q[i]);
      n_fall = n_fall + CNT_W'(pend_q[i] & ~pend_d[i]);
    end
    cnt_d = flush_i ? '0 : (cnt_q + n_rise - n_fall);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pending_o     = pend_q;
  assign pending_cnt_o = cnt_q;

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port GPR file (r0..r14) with two write ports, same-cycle bypass and hazard gating.
module regfile_mp_sb
  import regfile_mp_sb_pkg::*;
#(
  parameter int unsigned NUM_REGS = 15,
  parameter int unsigned DATA_LEN = 32,
  parameter int unsigned NUM_RD   = 3,
  parameter int unsigned BYPASS   = 1
) (
  input  logic            clk,
  input  logic            rst,
  regfile_mp_sb_if.slave  bus
);

  localparam logic [REG_ADDR_W-1:0] LAST_IDX = REG_ADDR_W'(NUM_REGS - 1);

  // PC is never stored here even if NUM_REGS were widened.
  function automatic logic addr_ok(input logic [REG_ADDR_W-1:0] a);
    return (a <= LAST_IDX) && (a != PC_IDX);
  endfunction

  logic [DATA_LEN-1:0]   regs_q [NUM_REGS];
  logic [DATA_LEN-1:0]   regs_d [NUM_REGS];
  logic [REG_ADDR_W-1:0] wa [NUM_WR];
  logic [DATA_LEN-1:0]   wd [NUM_WR];
  logic [NUM_WR-1:0]     wv;
  logic [REG_ADDR_W-1:0] ra [NUM_RD];
  logic [DATA_LEN-1:0]   rv [NUM_RD];
  logic [NUM_RD-1:0]     rhit;
  logic [NUM_REGS-1:0]   pending;

  always_comb begin
    for (int unsigned p = 0; p < NUM_WR; p++) begin
      wa[p] = bus.wr_addr[p*REG_ADDR_W +: REG_ADDR_W];
      wd[p] = bus.wr_data[p*DATA_LEN +: DATA_LEN];
      wv[p] = bus.wr_en[p] && addr_ok(wa[p]);
    end
  end

  // Highest port applied first so port 0 overwrites on an address collision.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REGS; i++) regs_d[i] = regs_q[i];
    for (int p = NUM_WR - 1; p >= 0; p--) begin
      if (wv[p]) regs_d[wa[p]] = wd[p];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= DATA_LEN'(rst_val(i));
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  // Combinational read with optional bypass from the write ports.
  always_comb begin
    bus.rd_data   = '0;
    bus.rd_hazard = '0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      ra[k]   = bus.rd_addr[k*REG_ADDR_W +: REG_ADDR_W];
      rv[k]   = '0;
      rhit[k] = 1'b0;
      if (addr_ok(ra[k])) begin
        rv[k] = regs_q[ra[k]];
        if (BYPASS != 0) begin
          for (int p = NUM_WR - 1; p >= 0; p--) begin
            if (wv[p] && (wa[p] == ra[k])) begin
              rhit[k] = 1'b1;
              rv[k]   = wd[p];
            end
          end
        end
        bus.rd_hazard[k] = pending[ra[k]] & ~rhit[k];
      end
      bus.rd_data[k*DATA_LEN +: DATA_LEN] = rv[k];
    end
  end

  regfile_mp_sb_scoreboard #(
    .NUM_REGS (NUM_REGS)
  ) u_sb (
    .clk           (clk),
    .rst           (rst),
    .flush_i       (bus.flush),
    .set_en_i      (bus.iss_en && addr_ok(bus.iss_dest)),
    .set_idx_i     (bus.iss_dest),
    .clr_en_i      (wv),
    .clr_idx_i     (bus.wr_addr),
    .pending_o     (pending),
    .pending_cnt_o (bus.pending_cnt)
  );

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench: vector table plus reset and read-sweep sequences, BYPASS=1 and BYPASS=0 in lockstep.
module tb_regfile_mp_sb;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  regfile_mp_sb_if #(.DATA_LEN(32), .NUM_RD(3)) if_b ();
  regfile_mp_sb_if #(.DATA_LEN(32), .NUM_RD(3)) if_n ();

  regfile_mp_sb #(.NUM_REGS(15), .DATA_LEN(32), .NUM_RD(3), .BYPASS(1)) u_dut (
    .clk (clk), .rst (rst), .bus (if_b.slave));
  regfile_mp_sb #(.NUM_REGS(15), .DATA_LEN(32), .NUM_RD(3), .BYPASS(0)) u_dut_nb (
    .clk (clk), .rst (rst), .bus (if_n.slave));

  assign if_n.rd_addr  = if_b.rd_addr;
  assign if_n.wr_en    = if_b.wr_en;
  assign if_n.wr_addr  = if_b.wr_addr;
  assign if_n.wr_data  = if_b.wr_data;
  assign if_n.iss_en   = if_b.iss_en;
  assign if_n.iss_dest = if_b.iss_dest;
  assign if_n.flush    = if_b.flush;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  ra0, ra1, ra2;
    logic [1:0]  we;
    logic [3:0]  wa0;
    logic [31:0] wd0;
    logic [3:0]  wa1;
    logic [31:0] wd1;
    logic        ie;
    logic [3:0]  id;
    logic        fl;
    logic [31:0] e0, e1, e2, enb0;
    logic [2:0]  ehz;
    logic [4:0]  ecnt;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  function automatic vec_t mk(
    input logic [3:0] ra0, input logic [3:0] ra1, input logic [3:0] ra2,
    input logic [1:0] we, input logic [3:0] wa0, input logic [31:0] wd0,
    input logic [3:0] wa1, input logic [31:0] wd1,
    input logic ie, input logic [3:0] id, input logic fl,
    input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2,
    input logic [31:0] enb0, input logic [2:0] ehz, input logic [4:0] ecnt);
    vec_t v;
    v.ra0 = ra0; v.ra1 = ra1; v.ra2 = ra2;
    v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
    v.ie = ie; v.id = id; v.fl = fl;
    v.e0 = e0; v.e1 = e1; v.e2 = e2; v.enb0 = enb0; v.ehz = ehz; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive_idle();
    if_b.rd_addr  = '0;
    if_b.wr_en    = '0;
    if_b.wr_addr  = '0;
    if_b.wr_data  = '0;
    if_b.iss_en   = 1'b0;
    if_b.iss_dest = '0;
    if_b.flush    = 1'b0;
  endtask

  // Expected register contents after the vector table has run.
  function automatic logic [31:0] post_val(input int i);
    case (i)
      3:       return 32'hA5A5A5A5;
      4:       return 32'h44444444;
      5:       return 32'h22222222;
      7:       return 32'hDEADBEEF;
      default: return 32'(i);
    endcase
  endfunction

  // Reads r0..r14 three at a time; also checks no hazards and the given count.
  task automatic sweep(input string tag, input bit after_table, input logic [4:0] ecnt);
    for (int b = 0; b < 15; b += 3) begin
      @(negedge clk);
      drive_idle();
      if_b.rd_addr = {4'(b + 2), 4'(b + 1), 4'(b)};
      #2;
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("%s_r%0d", tag, b + k), if_b.rd_data[k*32 +: 32],
            after_table ? post_val(b + k) : 32'(b + k));
      end
      chk($sformatf("%s_hz%0d", tag, b), 32'(if_b.rd_hazard), 32'd0);
      chk($sformatf("%s_cnt%0d", tag, b), 32'(if_b.pending_cnt), 32'(ecnt));
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    drive_idle();

    //        ra0 ra1 ra2 we     wa0 wd0           wa1 wd1           ie  id  fl  e0            e1            e2            enb0          hz      cnt
    vecs[0]  = mk(0, 1, 2, 2'b00, 0, 32'h0,        0, 32'h0,        0, 0,  0, 32'd0,        32'd1,        32'd2,        32'd0,        3'b000, 5'd0);
    vecs[1]  = mk(12,13,14,2'b00, 0, 32'h0,        0, 32'h0,        0, 0,  0, 32'd12,       32'd13,       32'd14,       32'd12,       3'b000, 5'd0);
    vecs[2]  = mk(3, 4, 5, 2'b11, 3, 32'hA5A5A5A5, 3, 32'h12345678, 0, 0,  0, 32'hA5A5A5A5, 32'd4,        32'd5,        32'd3,        3'b000, 5'd0);
    vecs[3]  = mk(7, 3, 15,2'b01, 7, 32'hDEADBEEF, 0, 32'h0,        0, 0,  0, 32'hDEADBEEF, 32'hA5A5A5A5, 32'd0,        32'd7,        3'b000, 5'd0);
    vecs[4]  = mk(7, 3, 5, 2'b00, 0, 32'h0,        0, 32'h0,        1, 5,  0, 32'hDEADBEEF, 32'hA5A5A5A5, 32'd5,        32'hDEADBEEF, 3'b000, 5'd0);
    vecs[5]  = mk(5, 0, 0, 2'b01, 5, 32'h11111111, 0, 32'h0,        1, 5,  0, 32'h11111111, 32'd0,        32'd0,        32'd5,        3'b000, 5'd1);
    vecs[6]  = mk(5, 6, 0, 2'b00, 0, 32'h0,        0, 32'h0,        0, 0,  0, 32'h11111111, 32'd6,        32'd0,        32'h11111111, 3'b001, 5'd1);
    vecs[7]  = mk(5, 0, 0, 2'b10, 0, 32'h0,        5, 32'h22222222, 0, 0,  0, 32'h22222222, 32'd0,        32'd0,        32'h11111111, 3'b000, 5'd1);
    vecs[8]  = mk(5, 0, 0, 2'b00, 0, 32'h0,        0, 32'h0,        1, 1,  0, 32'h22222222, 32'd0,        32'd0,        32'h22222222, 3'b000, 5'd0);
    vecs[9]  = mk(1, 2, 4, 2'b00, 0, 32'h0,        0, 32'h0,        1, 2,  0, 32'd1,        32'd2,        32'd4,        32'd1,        3'b001, 5'd1);
    vecs[10] = mk(1, 2, 4, 2'b00, 0, 32'h0,        0, 32'h0,        1, 4,  0, 32'd1,        32'd2,        32'd4,        32'd1,        3'b011, 5'd2);
    vecs[11] = mk(1, 2, 4, 2'b01, 4, 32'h44444444, 0, 32'h0,        0, 0,  1, 32'd1,        32'd2,        32'h44444444, 32'd1,        3'b011, 5'd3);
    vecs[12] = mk(4, 1, 2, 2'b00, 0, 32'h0,        0, 32'h0,        0, 0,  0, 32'h44444444, 32'd1,        32'd2,        32'h44444444, 3'b000, 5'd0);
    vecs[13] = mk(15,15,0, 2'b11, 15,32'hFFFFFFFF, 15,32'hFFFFFFFF, 1, 15, 0, 32'd0,        32'd0,        32'd0,        32'd0,        3'b000, 5'd0);
    vecs[14] = mk(15,14,0, 2'b00, 0, 32'h0,        0, 32'h0,        0, 0,  0, 32'd0,        32'd14,       32'd0,        32'd0,        3'b000, 5'd0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    sweep("rst0", 1'b0, 5'd0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      if_b.rd_addr  = {vecs[i].ra2, vecs[i].ra1, vecs[i].ra0};
      if_b.wr_en    = vecs[i].we;
      if_b.wr_addr  = {vecs[i].wa1, vecs[i].wa0};
      if_b.wr_data  = {vecs[i].wd1, vecs[i].wd0};
      if_b.iss_en   = vecs[i].ie;
      if_b.iss_dest = vecs[i].id;
      if_b.flush    = vecs[i].fl;
      #2;
      chk($sformatf("v%0d_rd0", i), if_b.rd_data[31:0],  vecs[i].e0);
      chk($sformatf("v%0d_rd1", i), if_b.rd_data[63:32], vecs[i].e1);
      chk($sformatf("v%0d_rd2", i), if_b.rd_data[95:64], vecs[i].e2);
      chk($sformatf("v%0d_nb_rd0", i), if_n.rd_data[31:0], vecs[i].enb0);
      chk($sformatf("v%0d_hazard", i), 32'(if_b.rd_hazard), 32'(vecs[i].ehz));
      chk($sformatf("v%0d_cnt", i), 32'(if_b.pending_cnt), 32'(vecs[i].ecnt));
    end

    sweep("post", 1'b1, 5'd0);

    // Reset while two registers are pending and writes/issue are active.
    @(negedge clk);
    drive_idle();
    if_b.iss_en = 1'b1; if_b.iss_dest = 4'd6;
    @(negedge clk);
    if_b.iss_dest = 4'd8;
    @(negedge clk);
    drive_idle();
    if_b.rd_addr = {4'd0, 4'd8, 4'd6};
    #2;
    chk("pre_rst_hazard", 32'(if_b.rd_hazard), 32'd3);
    chk("pre_rst_cnt", 32'(if_b.pending_cnt), 32'd2);
    @(negedge clk);
    rst = 1'b1;
    if_b.wr_en   = 2'b11;
    if_b.wr_addr = {4'd2, 4'd1};
    if_b.wr_data = {32'hCAFEF00D, 32'hFFFFFFFF};
    if_b.iss_en  = 1'b1; if_b.iss_dest = 4'd9;
    @(negedge clk);
    rst = 1'b0;
    drive_idle();
    if_b.rd_addr = {4'd9, 4'd8, 4'd6};
    #2;
    chk("post_rst_hazard", 32'(if_b.rd_hazard), 32'd0);
    chk("post_rst_cnt", 32'(if_b.pending_cnt), 32'd0);

    sweep("rst1", 1'b0, 5'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
